// File: rtl/dram_responder_pkg.sv
// Shared state encoding and default configuration for the DRAM responder slice.
package dram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck,
    StRelease
  } state_e;

  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefBlockW        = 256;
  localparam int unsigned DefDepthLog2     = 10;
  localparam int unsigned DefLatency       = 10;
  localparam int unsigned DefRefreshPeriod = 256;
  localparam int unsigned DefRefreshCycles = 8;

endpackage

// File: rtl/dram_responder_if.sv
// Request/response bus between a cache-line requester (master) and the DRAM responder (slave).
interface dram_responder_if #(
  parameter int unsigned ADDR_W  = dram_pkg::DefAddrW,
  parameter int unsigned BLOCK_W = dram_pkg::DefBlockW
);

  logic               mem_cs;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ack;
  logic               mem_busy;

  modport master (
    output mem_cs,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack,
    input  mem_busy
  );

  modport slave (
    input  mem_cs,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack,
    output mem_busy
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Periodic refresh scheduler: a request every REFRESH_PERIOD cycles opens a REFRESH_CYCLES-long
// window, deferred (pending) until the responder is idle. Used only under DRAM_REFRESH_EN.
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = DefRefreshPeriod,
  parameter int unsigned REFRESH_CYCLES = DefRefreshCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  output logic block
);

  localparam int unsigned PerW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned WinW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [PerW-1:0] per_q;
  logic [WinW-1:0] win_q;
  logic            pending_q;
  logic            req;
  logic            start;

  assign req   = (per_q == PerW'(REFRESH_PERIOD - 1));
  assign start = (req || pending_q) && idle && (win_q == '0);
  // The window covers the start cycle plus REFRESH_CYCLES-1 counted cycles.
  assign block = start || (win_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q     <= '0;
      win_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      per_q     <= req ? '0 : per_q + 1'b1;
      pending_q <= start ? 1'b0 : (pending_q || req);
      if (start) begin
        win_q <= WinW'(REFRESH_CYCLES - 1);
      end else if (win_q != '0) begin
        win_q <= win_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Fixed-latency cache-line DRAM model with an inline storage array.
// Optional periodic refresh windows are enabled by defining DRAM_REFRESH_EN.
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned BLOCK_W        = DefBlockW,
  parameter int unsigned DEPTH_LOG2     = DefDepthLog2,
  parameter int unsigned LATENCY        = DefLatency,
  parameter int unsigned REFRESH_PERIOD = DefRefreshPeriod,
  parameter int unsigned REFRESH_CYCLES = DefRefreshCycles
) (
  input  logic             clk,
  input  logic             rst,
  dram_responder_if.slave  mem
);

  localparam int unsigned Off  = $clog2(BLOCK_W / 8);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [BLOCK_W-1:0]      wdata_q;
  logic [BLOCK_W-1:0]      rdata_q;
  logic                    ack_q;
  logic                    refresh_block;
  logic                    access_now;

  logic [BLOCK_W-1:0]      array_q [0:(1 << DEPTH_LOG2) - 1];

  // Offset and upper address bits are deliberately ignored: lines alias modulo the array.
  logic unused_addr;
  assign unused_addr = ^mem.mem_addr;

`ifdef DRAM_REFRESH_EN
  dram_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk   (clk),
    .rst   (rst),
    .idle  (state_q == StIdle),
    .block (refresh_block)
  );
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = ^{REFRESH_PERIOD, REFRESH_CYCLES};
  assign refresh_block      = 1'b0;
`endif

  assign access_now = (state_q == StBusy) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem.mem_cs && !refresh_block) begin
            we_q    <= mem.mem_we;
            idx_q   <= mem.mem_addr[Off+DEPTH_LOG2-1:Off];
            wdata_q <= mem.mem_wdata;
            cnt_q   <= CntW'(LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!we_q) begin
              rdata_q <= array_q[idx_q];
            end
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: state_q <= StRelease;
        StRelease: begin
          // A strobe still held after the ack must not start another access.
          if (!mem.mem_cs) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && access_now && we_q) begin
      array_q[idx_q] <= wdata_q;
    end
  end

  assign mem.mem_rdata = rdata_q;
  assign mem.mem_ack   = ack_q;
  assign mem.mem_busy  = (state_q != StIdle) || refresh_block;

endmodule

// File: tb/tb_dram_responder.sv
// Directed plus randomized bench for dram_responder against a line-addressed memory model.
module tb_dram_responder;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BLOCK_W    = 256;
  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned LATENCY    = 4;
  localparam int unsigned RP         = 16;
  localparam int unsigned RC         = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dram_responder_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) mem_if ();

  dram_responder #(
    .ADDR_W         (ADDR_W),
    .BLOCK_W        (BLOCK_W),
    .DEPTH_LOG2     (DEPTH_LOG2),
    .LATENCY        (LATENCY),
    .REFRESH_PERIOD (RP),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mem_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one entry per cache line, plus the last value a read returned.
  logic [BLOCK_W-1:0] model [int];
  logic [BLOCK_W-1:0] last_rdata;
  bit                 rd_known;

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'((a / (BLOCK_W / 8)) % (1 << DEPTH_LOG2));
  endfunction

  task automatic check(input string tag, input logic [BLOCK_W-1:0] obs,
                       input logic [BLOCK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_block(output logic [BLOCK_W-1:0] b);
    for (int i = 0; i < BLOCK_W / 32; i++) b[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_accept();
    int k = 0;
    while (mem_if.mem_busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("accept_timeout", BLOCK_W'(mem_if.mem_busy), '0);
  endtask

  // Assumes the request is on the bus and busy was low at this negedge: latch is the next posedge.
  task automatic run_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [BLOCK_W-1:0] wdata, input int hold,
                            input bit drop_early, input bit scramble);
    int k = 0;
    int n = 0;
    int extra_acks = 0;
    bit acked = 0;
    int i = idx_of(addr);
    logic [BLOCK_W-1:0] junk;
    while (!acked && k < int'(LATENCY) + 10) begin
      @(negedge clk);
      k++;
      if (k == 1 && drop_early) mem_if.mem_cs = 1'b0;
      if (k == 1 && scramble) begin
        rand_block(junk);
        mem_if.mem_addr  = $urandom;
        mem_if.mem_wdata = junk;
        mem_if.mem_we    = ~we;
      end
      if (mem_if.mem_ack === 1'b1) acked = 1;
    end
    check("ack_latency", BLOCK_W'(k), BLOCK_W'(LATENCY + 1));
    if (we) begin
      model[i] = wdata;
      if (rd_known) check("wr_keeps_rdata", mem_if.mem_rdata, last_rdata);
    end else if (model.exists(i)) begin
      check("rd_data", mem_if.mem_rdata, model[i]);
      last_rdata = model[i];
      rd_known   = 1;
    end else begin
      rd_known = 0;
    end
    if (!drop_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (mem_if.mem_ack !== 1'b0) extra_acks++;
        check("release_hold", BLOCK_W'(mem_if.mem_busy), BLOCK_W'(1));
      end
    end
    mem_if.mem_cs = 1'b0;
    while (n < 4) begin
      @(negedge clk);
      n++;
      if (mem_if.mem_ack !== 1'b0) extra_acks++;
      if (mem_if.mem_busy === 1'b0) break;
    end
    check("single_ack", BLOCK_W'(extra_acks), '0);
`ifndef DRAM_REFRESH_EN
    check("release_exit", BLOCK_W'(n), BLOCK_W'((drop_early || hold == 0) ? 2 : 1));
`endif
  endtask

  task automatic access(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [BLOCK_W-1:0] wdata, input int hold,
                        input bit drop_early, input bit scramble);
    @(negedge clk);
    mem_if.mem_cs    = 1'b1;
    mem_if.mem_we    = we;
    mem_if.mem_addr  = addr;
    mem_if.mem_wdata = wdata;
    wait_accept();
    run_access(we, addr, wdata, hold, drop_early, scramble);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BLOCK_W-1:0] d;
    logic [BLOCK_W-1:0] d_old;
    logic [BLOCK_W-1:0] pattern;
    int pool [8];
    int acks;

    rst              = 1'b1;
    mem_if.mem_cs    = 1'b0;
    mem_if.mem_we    = 1'b0;
    mem_if.mem_addr  = '0;
    mem_if.mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", BLOCK_W'(mem_if.mem_busy), '0);
    check("rst_ack", BLOCK_W'(mem_if.mem_ack), '0);
    check("rst_rdata", mem_if.mem_rdata, '0);
    rst        = 1'b0;
    last_rdata = '0;
    rd_known   = 1;

`ifdef DRAM_REFRESH_EN
    begin
      int k = 0;
      int nbusy = 0;
      while (mem_if.mem_busy !== 1'b1 && k < 64) begin
        @(negedge clk);
        k++;
      end
      if (k >= 64) check("refresh_timeout", BLOCK_W'(mem_if.mem_busy), BLOCK_W'(1));
      rand_block(d);
      mem_if.mem_cs    = 1'b1;
      mem_if.mem_we    = 1'b1;
      mem_if.mem_addr  = 32'h200;
      mem_if.mem_wdata = d;
      while (mem_if.mem_busy === 1'b1 && nbusy < 10) begin
        nbusy++;
        @(negedge clk);
      end
      check("refresh_window", BLOCK_W'(nbusy), BLOCK_W'(RC));
      run_access(1'b1, 32'h200, d, 0, 0, 0);
      access(1'b0, 32'h200, '0, 0, 0, 0);
    end
`endif

    // Write then read of one line with a recognisable pattern.
    pattern = {(BLOCK_W / 8){8'hA5}};
    access(1'b1, 32'h40, pattern, 0, 0, 0);
    access(1'b0, 32'h40, '0, 0, 0, 0);
    check("a5_readback", mem_if.mem_rdata, pattern);

    // Strobe held three cycles past the ack.
    access(1'b0, 32'h40, '0, 3, 0, 0);

    // Alias: 0x8000 maps onto the same line as 0x0.
    rand_block(d);
    access(1'b1, 32'h0, d, 1, 0, 0);
    access(1'b0, 32'h8000, '0, 0, 0, 0);
    check("alias_readback", mem_if.mem_rdata, d);

    // Strobe dropped mid-access, and inputs scrambled mid-access.
    rand_block(d);
    access(1'b1, 32'h100, d, 0, 1, 0);
    rand_block(d);
    access(1'b1, 32'h120, d, 2, 0, 1);
    access(1'b0, 32'h100, '0, 0, 1, 1);
    access(1'b0, 32'h120, '0, 1, 0, 0);

    // Reset two cycles into a write aborts it.
    rand_block(d_old);
    access(1'b1, 32'h80, d_old, 0, 0, 0);
    rand_block(d);
    @(negedge clk);
    mem_if.mem_cs    = 1'b1;
    mem_if.mem_we    = 1'b1;
    mem_if.mem_addr  = 32'h80;
    mem_if.mem_wdata = d;
    wait_accept();
    repeat (2) @(negedge clk);
    rst           = 1'b1;
    mem_if.mem_cs = 1'b0;
    @(negedge clk);
    check("abort_ack", BLOCK_W'(mem_if.mem_ack), '0);
    check("abort_busy", BLOCK_W'(mem_if.mem_busy), '0);
    check("abort_rdata", mem_if.mem_rdata, '0);
    @(negedge clk);
    rst        = 1'b0;
    last_rdata = '0;
    rd_known   = 1;
    acks       = 0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (mem_if.mem_ack !== 1'b0) acks++;
    end
    check("abort_no_ack", BLOCK_W'(acks), '0);
    access(1'b0, 32'h80, '0, 0, 0, 0);
    check("abort_prior", mem_if.mem_rdata, d_old);

    // Randomized traffic over a small line pool with random offset/upper alias bits.
    for (int p = 0; p < 8; p++) begin
      pool[p] = int'($urandom_range(0, (1 << DEPTH_LOG2) - 1));
      rand_block(d);
      access(1'b1, ADDR_W'(pool[p] * (BLOCK_W / 8)), d, 0, 0, 0);
    end
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      logic w;
      a = ADDR_W'(pool[$urandom_range(0, 7)] * (BLOCK_W / 8) + $urandom_range(0, BLOCK_W / 8 - 1))
          + (ADDR_W'($urandom_range(0, 7)) << (DEPTH_LOG2 + $clog2(BLOCK_W / 8)));
      w = 1'($urandom_range(0, 1));
      rand_block(d);
      access(w, a, d, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 The block SHALL have parameter BLOCK_W, default 256, transfer width in bits; it is one cache line.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of stored blocks.
REQ-004 The block SHALL have parameter LATENCY, default 10, access latency in cycles; legal values are 1 or more.
REQ-005 The block SHALL have parameter REFRESH_PERIOD, default 256, cycles between refresh windows.
REQ-006 The block SHALL have parameter REFRESH_CYCLES, default 8, refresh window length in cycles.
REQ-007 The block SHALL have port clk, input, width 1: the single clock; all logic is on the rising edge.
REQ-008 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-009 The block SHALL have port mem_cs, input, width 1: request strobe, held by the requester until mem_ack.
REQ-010 The block SHALL have port mem_we, input, width 1: 1 = write, 0 = read.
REQ-011 The block SHALL have port mem_addr, input, width ADDR_W: byte address.
REQ-012 The block SHALL have port mem_wdata, input, width BLOCK_W: write block.
REQ-013 The block SHALL have port mem_rdata, output, width BLOCK_W: read block, registered.
REQ-014 The block SHALL have port mem_ack, output, width 1: one-cycle completion pulse, registered.
REQ-015 The block SHALL have port mem_busy, output, width 1: high when a new request cannot be accepted this cycle.

Function
REQ-016 States SHALL be IDLE, BUSY, ACK and RELEASE.
REQ-017 In IDLE, with mem_cs=1 and no refresh active, the block SHALL latch mem_addr, mem_we and mem_wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-018 Input changes after the latch point SHALL be ignored until the next acceptance.
REQ-019 In BUSY with the counter nonzero, the block SHALL decrement the counter.
REQ-020 In BUSY with the counter at 0, the block SHALL write array[idx] on a write or load mem_rdata from array[idx] on a read, then go to ACK.
REQ-021 Index idx SHALL be addr[OFF+DEPTH_LOG2-1:OFF], where OFF = log2(BLOCK_W/8).
REQ-022 Offset bits and upper address bits SHALL be ignored, so addresses alias modulo the array size.
REQ-023 mem_ack SHALL be 1 for exactly one cycle, in ACK.
REQ-024 For a request latched at edge E, mem_ack SHALL be high in the cycle following edge E+LATENCY.
REQ-025 mem_rdata SHALL be valid in the ACK cycle and hold until the next read completes; writes SHALL NOT change mem_rdata.
REQ-026 From ACK the block SHALL go to RELEASE.
REQ-027 In RELEASE the block SHALL stay until mem_cs=0, then go to IDLE; a held strobe never starts a second access.
REQ-028 If mem_cs drops during BUSY, the access SHALL still complete, mem_ack SHALL still pulse, and RELEASE SHALL exit on the next cycle.
REQ-029 mem_busy SHALL be 1 whenever the state is not IDLE or a refresh window is active.
REQ-030 A read-after-write to the same idx SHALL return the written block.

Reset
REQ-031 While rst=1, the state SHALL go to IDLE, and mem_ack, mem_busy, mem_rdata and the counter SHALL be 0.
REQ-032 Reset during BUSY SHALL abort the access with no array write and no mem_ack.
REQ-033 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-034 With macro DRAM_REFRESH_EN defined, a free-running counter SHALL raise a refresh request every REFRESH_PERIOD cycles.
REQ-035 A refresh request SHALL open a window of REFRESH_CYCLES cycles only when the state is IDLE; a request arriving mid-access SHALL be held pending until IDLE.
REQ-036 During a refresh window, mem_cs SHALL NOT be accepted; a held request SHALL be accepted in the first cycle after the window closes.
REQ-037 When refresh and mem_cs coincide in IDLE, refresh SHALL win.
REQ-038 Without DRAM_REFRESH_EN, no refresh logic SHALL exist and mem_busy SHALL equal (state != IDLE).

Structure
REQ-039 Package dram_pkg SHALL hold the state encoding and the default parameter constants.
REQ-040 The refresh counter, pending flag and window logic SHALL be sub-module dram_refresh_timer, instantiated only under DRAM_REFRESH_EN.
REQ-041 The storage array SHALL be inline in dram_responder.

Verification
REQ-042 With LATENCY=4, a write to 0x40 of 0xA5.. followed by a read of 0x40 SHALL give mem_ack 5 cycles after each latch and return mem_rdata=0xA5...
REQ-043 With mem_cs held high for 3 cycles after mem_ack, the bench SHALL observe exactly one access and one mem_ack, and RELEASE held until mem_cs=0.
REQ-044 With DEPTH_LOG2=10 and BLOCK_W=256, a write to 0x0 followed by a read of 0x8000 SHALL return the same data (alias).
REQ-045 Asserting rst 2 cycles into a write to 0x80 SHALL produce no mem_ack, and a later read of 0x80 SHALL return the prior contents.
REQ-046 With DRAM_REFRESH_EN, REFRESH_PERIOD=16 and REFRESH_CYCLES=3, mem_cs raised at the refresh edge SHALL be latched 3 cycles later, with mem_busy=1 throughout the window.
REQ-047 With mem_addr and mem_wdata changed mid-BUSY, the write SHALL land at the originally latched address with the originally latched data.
